// File: rtl/alu_seq_exec.sv
// alu_seq_exec: EX-stage ALU with single-cycle add/sub/logic ops and an iterative 1-bit-per-cycle shifter
module alu_seq_exec #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       aluControl,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int M = WIDTH - 1;

   state_t           state_q, state_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] sum, diff, alu_res, step;
   logic             add_ovf, sub_ovf, alu_ovf, is_shift;

   // single-cycle datapath on the live operands; subtract overflow uses the sign of B before negation
   always_comb begin
      sum      = opA + opB;
      diff     = opA - opB;
      add_ovf  = (opA[M] == opB[M]) && (sum[M] != opA[M]);
      sub_ovf  = (opA[M] != opB[M]) && (diff[M] != opA[M]);
      is_shift = (aluControl == 4'd6) || (aluControl == 4'd7) || (aluControl == 4'd8);
      alu_res  = (aluControl <= 4'd1) ? sum :
                 (aluControl == 4'd2) ? diff :
                 (aluControl == 4'd3) ? (opA & opB) :
                 (aluControl == 4'd4) ? (opA | opB) :
                 (aluControl == 4'd5) ? (opA ^ opB) : opA;
      alu_ovf  = (aluControl <= 4'd1) ? add_ovf :
                 (aluControl == 4'd2) ? sub_ovf : 1'b0;
   end

   // one-bit shift of the working register in the direction of the captured opcode
   always_comb begin
      step = (ctrl_q == 4'd7) ? {work_q[M-1:0], 1'b0} :
             (ctrl_q == 4'd8) ? {work_q[M], work_q[M:1]} :
                                {1'b0, work_q[M:1]};
   end

   // next-state logic; result and flags change only on entry to DONE
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start && is_shift) begin
               ctrl_d = aluControl;
               work_d = opA;
               cnt_d  = opB[SHW-1:0];
               if (opB[SHW-1:0] == '0) begin
                  result_d = opA;
                  zero_d   = ~|opA;
                  ovf_d    = 1'b0;
                  state_d  = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end else if (start) begin
               result_d = alu_res;
               zero_d   = ~|alu_res;
               ovf_d    = alu_ovf;
               state_d  = DONE;
            end
         end
         SHIFT: begin
            work_d = step;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d = step;
               zero_d   = ~|step;
               ovf_d    = 1'b0;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ctrl_q   <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
endmodule
